rgb_led_pwm_driver: RTL and testbench

// - Downstream stage of the 2-bit compare/RGB decoder; consumes its red/green/blue flags, drives three PWM LED pins.
// - Synchronises flags; applies enable and brightness changes only at PWM period boundaries (glitch-free).
// - Sits between the decoder and board LED pins; one clock domain.

---
 rtl/rgb_led_pkg.sv | 27 ++
 rtl/rgb_pwm_channel.sv | 77 +++++++
 rtl/rgb_led_pwm_driver.sv | 111 +++++++++++
 tb/tb_rgb_led_pwm_driver.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_led_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rgb_led_pkg
// Brief   : Shared types and defaults for the RGB LED PWM driver.
// Revision: 1.0 - initial release
// ============================================================================
package rgb_led_pkg;

  // One flag per colour.
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  // Channel identifiers.
  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } rgb_ch_e;

  // Default PWM counter width.
  localparam int RGB_CNT_W_DEF = 4;

endpackage
`default_nettype wire

// File: rtl/rgb_pwm_channel.sv
`default_nettype none
// ============================================================================
// Module  : rgb_pwm_channel
// Brief   : One LED channel. It synchronises the colour flag, latches the
//           enable at period boundaries, optionally fades the level, and
//           registers the PWM compare output.
//           Macro RGB_FADE_EN: when defined, the level ramps toward the
//           target by FADE_STEP per period.
// Revision: 1.0 - initial release
// ============================================================================
module rgb_pwm_channel
  import rgb_led_pkg::*;
#(
  parameter int CNT_W      = RGB_CNT_W_DEF,
  parameter bit ACTIVE_LOW = 1'b0,
  parameter int FADE_STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_in,
  input  logic [CNT_W-1:0] cnt,
  input  logic             wrap,
  input  logic [CNT_W-1:0] duty_act,
  output logic             led
);

  logic             sync1;
  logic             sync2;
  logic             en;
  logic [CNT_W-1:0] tgt;
  logic [CNT_W-1:0] level;

  assign tgt = en ? duty_act : '0;

  // Two-flop synchroniser for the asynchronous colour flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= flag_in;
      sync2 <= sync1;
    end
  end

  // The enable changes only at the last count of a period, so no pulse is cut short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    en <= 1'b0;
    else if (wrap) en <= sync2;
  end

`ifdef RGB_FADE_EN
  localparam logic [CNT_W-1:0] STEP = CNT_W'(FADE_STEP);

  // Step the level toward the target once per period and stop exactly on the target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
    end else if (wrap) begin
      if (level < tgt)
        level <= ((tgt - level) > STEP) ? level + STEP : tgt;
      else if (level > tgt)
        level <= ((level - tgt) > STEP) ? level - STEP : tgt;
    end
  end
`else
  assign level = tgt;
`endif

  // Registered compare output. A level of MAX still leaves one off cycle per period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led <= ACTIVE_LOW;
    else        led <= (cnt < level) ^ ACTIVE_LOW;
  end

endmodule
`default_nettype wire

// File: rtl/rgb_led_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module  : rgb_led_pwm_driver
// Brief   : Three-channel PWM LED driver fed by the RGB decoder flags. It
//           owns the shared period counter and the duty registers. Duty and
//           enable changes take effect only at period boundaries.
//           Macro RGB_FADE_EN: when defined, each channel fades its level.
// Revision: 1.0 - initial release
// ============================================================================
module rgb_led_pwm_driver
  import rgb_led_pkg::*;
#(
  parameter int CNT_W        = RGB_CNT_W_DEF,
  parameter int DUTY_DEFAULT = 8,
  parameter bit ACTIVE_LOW   = 1'b0,
  parameter int FADE_STEP    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             red_in,
  input  logic             green_in,
  input  logic             blue_in,
  input  logic [CNT_W-1:0] duty_in,
  input  logic             duty_load,
  output logic             led_r,
  output logic             led_g,
  output logic             led_b,
  output logic             pwm_wrap
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] DUTY_RST = CNT_W'(DUTY_DEFAULT);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] duty_pend;
  logic [CNT_W-1:0] duty_act;
  logic             wrap;
  rgb_t             flags;
  rgb_t             leds;

  assign wrap     = (cnt == CNT_MAX);
  assign pwm_wrap = wrap;
  assign flags    = '{r: red_in, g: green_in, b: blue_in};
  assign led_r    = leds.r;
  assign led_g    = leds.g;
  assign led_b    = leds.b;

  // Free-running period counter. It wraps from MAX back to 0 naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + 1'b1;
  end

  // A load always updates the pending duty. The active duty changes only at
  // the wrap, and a load in the wrap cycle goes straight through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_pend <= DUTY_RST;
      duty_act  <= DUTY_RST;
    end else begin
      if (duty_load)
        duty_pend <= duty_in;
      if (wrap)
        duty_act <= duty_load ? duty_in : duty_pend;
    end
  end

  rgb_pwm_channel #(
    .CNT_W      (CNT_W),
    .ACTIVE_LOW (ACTIVE_LOW),
    .FADE_STEP  (FADE_STEP)
  ) u_ch_r (
    .clk      (clk),
    .rst_n    (rst_n),
    .flag_in  (flags.r),
    .cnt      (cnt),
    .wrap     (wrap),
    .duty_act (duty_act),
    .led      (leds.r)
  );

  rgb_pwm_channel #(
    .CNT_W      (CNT_W),
    .ACTIVE_LOW (ACTIVE_LOW),
    .FADE_STEP  (FADE_STEP)
  ) u_ch_g (
    .clk      (clk),
    .rst_n    (rst_n),
    .flag_in  (flags.g),
    .cnt      (cnt),
    .wrap     (wrap),
    .duty_act (duty_act),
    .led      (leds.g)
  );

  rgb_pwm_channel #(
    .CNT_W      (CNT_W),
    .ACTIVE_LOW (ACTIVE_LOW),
    .FADE_STEP  (FADE_STEP)
  ) u_ch_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .flag_in  (flags.b),
    .cnt      (cnt),
    .wrap     (wrap),
    .duty_act (duty_act),
    .led      (leds.b)
  );

endmodule
`default_nettype wire

// File: tb/tb_rgb_led_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_rgb_led_pwm_driver
// Brief   : Scoreboard bench for rgb_led_pwm_driver (CNT_W=4, DUTY_DEFAULT=8,
//           ACTIVE_LOW=0, FADE_STEP=2). For each PWM period it records the
//           expected on-time of every channel. The LED output lags the
//           counter by one clock, so a window runs from cnt=1 of one period
//           through cnt=0 of the next.
//           Macro RGB_FADE_EN: when defined, the reference model also fades.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rgb_led_pwm_driver;

  localparam int CNT_W  = 4;
  localparam int PERIOD = 16;
  localparam int STEP   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       red_in = 1'b0;
  logic       green_in = 1'b0;
  logic       blue_in = 1'b0;
  logic [3:0] duty_in = 4'd0;
  logic       duty_load = 1'b0;
  logic       led_r;
  logic       led_g;
  logic       led_b;
  logic       pwm_wrap;

  always #5 clk = ~clk;

  rgb_led_pwm_driver #(
    .CNT_W        (CNT_W),
    .DUTY_DEFAULT (8),
    .ACTIVE_LOW   (1'b0),
    .FADE_STEP    (STEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .red_in    (red_in),
    .green_in  (green_in),
    .blue_in   (blue_in),
    .duty_in   (duty_in),
    .duty_load (duty_load),
    .led_r     (led_r),
    .led_g     (led_g),
    .led_b     (led_b),
    .pwm_wrap  (pwm_wrap)
  );

  typedef struct {
    int r;
    int g;
    int b;
  } ontime_t;

  ontime_t sb_q[$];
  int      total = 0;
  int      bad = 0;
  int      en_m[3];
  int      lvl_m[3];
  int      act_m;
  int      pend_m;
  int      on_cnt[3];
  bit      win_open;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int fade_step(input int lvl, input int tgt);
    if (lvl < tgt) return (tgt - lvl > STEP) ? lvl + STEP : tgt;
    if (lvl > tgt) return (lvl - tgt > STEP) ? lvl - STEP : tgt;
    return lvl;
  endfunction

  task automatic model_reset();
    ontime_t z;
    for (int i = 0; i < 3; i++) begin
      en_m[i]  = 0;
      lvl_m[i] = 0;
    end
    act_m    = 8;
    pend_m   = 8;
    win_open = 1'b0;
    sb_q.delete();
    z.r = 0; z.g = 0; z.b = 0;
    sb_q.push_back(z);
  endtask

  // Close the running window and compare it with the oldest expectation.
  task automatic close_window(input int pid);
    ontime_t e;
    if (win_open) begin
      if (sb_q.size() == 0) begin
        check($sformatf("sb_empty_p%0d", pid), 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("on_r_p%0d", pid), on_cnt[0], e.r);
        check($sformatf("on_g_p%0d", pid), on_cnt[1], e.g);
        check($sformatf("on_b_p%0d", pid), on_cnt[2], e.b);
      end
    end
    for (int i = 0; i < 3; i++) on_cnt[i] = 0;
    win_open = 1'b1;
  endtask

  // Run one full period. The task starts at the negedge of the cnt=0 cycle.
  // It sets the flags at cnt=5, can pulse green for one clock, and issues up
  // to two duty loads (a load at cnt=15 is the bypass case). rc >= 0
  // asserts reset at that count.
  task automatic run_period(input int pid, input bit r, input bit g, input bit b,
                            input int l1c, input int l1d, input int l2c, input int l2d,
                            input bit gp, input int rc);
    int      byp;
    int      tgt_cur[3];
    bit      fl[3];
    ontime_t e;
    byp = -1;
    for (int c = 0; c < PERIOD; c++) begin
      if (c == 0) begin
        close_window(pid);
        check($sformatf("wrap_lo_p%0d", pid), pwm_wrap, 32'd0);
      end else begin
        on_cnt[0] += int'(led_r);
        on_cnt[1] += int'(led_g);
        on_cnt[2] += int'(led_b);
      end
      if (c == PERIOD - 1) check($sformatf("wrap_hi_p%0d", pid), pwm_wrap, 32'd1);
      if (c == rc) begin
        check("pre_rst_led_r", led_r, (sb_q[0].r > c - 1) ? 32'd1 : 32'd0);
        rst_n = 1'b0;
        duty_load = 1'b0;
        #1;
        check("rst_led_r", led_r, 32'd0);
        check("rst_led_g", led_g, 32'd0);
        check("rst_wrap", pwm_wrap, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        return;
      end
      duty_load = 1'b0;
      if (c == 5) begin
        red_in = r; green_in = g; blue_in = b;
      end
      if (gp && c == 8) green_in = 1'b1;
      if (gp && c == 9) green_in = g;
      if (c == l1c) begin
        duty_in = 4'(l1d); duty_load = 1'b1; pend_m = l1d;
        if (c == PERIOD - 1) byp = l1d;
      end
      if (c == l2c) begin
        duty_in = 4'(l2d); duty_load = 1'b1; pend_m = l2d;
        if (c == PERIOD - 1) byp = l2d;
      end
      @(negedge clk);
    end
    duty_load = 1'b0;
    // Reference behaviour at the period boundary.
    fl[0] = r; fl[1] = g; fl[2] = b;
    for (int i = 0; i < 3; i++) tgt_cur[i] = (en_m[i] != 0) ? act_m : 0;
    act_m = (byp >= 0) ? byp : pend_m;
    for (int i = 0; i < 3; i++) begin
      en_m[i]  = int'(fl[i]);
      lvl_m[i] = fade_step(lvl_m[i], tgt_cur[i]);
    end
`ifdef RGB_FADE_EN
    e.r = lvl_m[0]; e.g = lvl_m[1]; e.b = lvl_m[2];
`else
    e.r = (en_m[0] != 0) ? act_m : 0;
    e.g = (en_m[1] != 0) ? act_m : 0;
    e.b = (en_m[2] != 0) ? act_m : 0;
`endif
    sb_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 3; i++) on_cnt[i] = 0;
    red_in = 1'b1;
    repeat (3) @(negedge clk);
    check("rstq_led_r", led_r, 32'd0);
    check("rstq_led_b", led_b, 32'd0);
    check("rstq_wrap", pwm_wrap, 32'd0);
    rst_n = 1'b1;
    model_reset();
    // pid, r, g, b, load1 cnt/val, load2 cnt/val, green pulse, reset cnt
    run_period( 0, 1, 0, 0, -1,  0, -1,  0, 0, -1);
    run_period( 1, 1, 0, 0, -1,  0, -1,  0, 0, -1);
    run_period( 2, 1, 0, 0, -1,  0, -1,  0, 0, -1);
    run_period( 3, 1, 0, 0,  6,  3, -1,  0, 0, -1);
    run_period( 4, 1, 0, 0,  7,  0, -1,  0, 0, -1);
    run_period( 5, 1, 0, 0, 15, 15, -1,  0, 0, -1);
    run_period( 6, 1, 0, 0,  3,  5,  9, 12, 0, -1);
    run_period( 7, 1, 0, 0, -1,  0, -1,  0, 1, -1);
    run_period( 8, 1, 1, 1, -1,  0, -1,  0, 0, -1);
    run_period( 9, 0, 1, 1, -1,  0, -1,  0, 0, -1);
    run_period(10, 1, 0, 0, -1,  0, -1,  0, 0, -1);
    run_period(11, 1, 0, 0, -1,  0, -1,  0, 0, -1);
    run_period(12, 1, 0, 0, -1,  0, -1,  0, 0,  3);
    run_period(20, 1, 0, 0, -1,  0, -1,  0, 0, -1);
    run_period(21, 1, 0, 0, -1,  0, -1,  0, 0, -1);
    run_period(22, 0, 0, 0, -1,  0, -1,  0, 0, -1);
    for (int p = 0; p < 6; p++)
      run_period(30 + p, 0, 0, 1, -1, 0, -1, 0, 0, -1);
    for (int p = 0; p < 6; p++)
      run_period(40 + p, 0, 0, 0, -1, 0, -1, 0, 0, -1);
    run_period(50, 0, 0, 0, -1, 0, -1, 0, 0, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
